seq_det_sched: RTL and testbench
================================

# seq_det_sched

Round-robin scheduler that shares one overlapping Mealy "101 or 110" detection datapath among N_CH serial bit streams. Each channel keeps its own 2-bit detector context, so interleaving bits from different channels never corrupts a partial match. The block sits between the serial input sources and downstream hit consumers. It reports each detection with its channel and pattern, plus optional per-channel hit counts.

## Interface
- N_CH, 4: number of requesting channels, 2..8.
- BURST, 4: maximum consecutive accepted bits per grant while another channel is waiting, ≥1.
- CNT_W, 8: per-channel hit counter width.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  N_CH  channel i offers a bit.
- in_bit  in  N_CH  serial data bit of channel i.
- in_ready  out  N_CH  one-hot or zero; channel i is granted.
- flush  in  N_CH  clears channel i's context (and counter).
- hit  out  1  registered one-cycle detection pulse.
- hit_ch  out  clog2(N_CH)  channel of the current hit.
- hit_pat  out  1  0 = "101", 1 = "110".
- busy  out  1  a grant is active.
- hit_cnt  out  N_CH*CNT_W  packed per-channel counters, channel 0 in LSBs.

## Operation
- Transfer on channel i: in_valid[i] & in_ready[i] in the same cycle.
- Per-channel context ctx[i] holds one of four states, A=00, B=01, C=10, D=11:
  - A: bit 1 goes to B; bit 0 stays A.
  - B: 1 goes to C; 0 goes to D.
  - C: 1 stays C; 0 goes to D.
  - D: 1 goes to B; 0 goes to A.
- Detection on a transfer:
  - ctx C with bit 0: hit, pattern 110.
  - ctx D with bit 1: hit, pattern 101.
  - Detection is overlapping.
- Scheduler FSM states:
  - IDLE: in_ready=0. If any in_valid, grant the first valid channel at or after rr_ptr, scanning cyclically. Go to GRANT and clear burst_cnt.
  - GRANT: in_ready[gnt_ch]=1. Each transfer increments burst_cnt.
- Release from GRANT to IDLE happens in either case, and sets rr_ptr to (gnt_ch+1) mod N_CH:
  - (a) The owner's in_valid is 0 in a GRANT cycle. No transfer occurs that cycle.
  - (b) A transfer makes burst_cnt reach BURST while some other channel has in_valid=1.
- At the burst limit with no other channel valid: keep the grant and reset burst_cnt to 0.
- flush[i]: ctx[i] becomes A next cycle.
  - Flush coinciding with a transfer on i: the bit is accepted (handshake completes), ctx[i] becomes A, no hit is reported.
  - Flush does not affect arbitration.
- Reset values: ctx all A, FSM IDLE, rr_ptr 0, burst_cnt 0, in_ready 0, hit 0, hit_ch 0, hit_pat 0, busy 0, hit_cnt 0.
- Reset asserted mid-grant drops the grant in the next cycle and discards any in-flight hit.

## Timing
- Detection latency: hit, hit_ch and hit_pat assert in the cycle after the transfer, for exactly one cycle.
- Sustained throughput: one bit per cycle within a grant.
- Each release costs one IDLE bubble cycle before the next grant.
- in_ready and busy are registered-state decodes: no combinational path from in_valid.
- Starvation bound: a waiting channel is granted within (N_CH-1)*(BURST+1)+1 cycles.
- ctx and counter updates are visible on the cycle after the transfer.

## Configuration
- SEQ_DET_HIT_CNT_EN defined:
  - Each channel has a CNT_W-bit counter that increments on every reported hit of that channel.
  - Counters saturate at 2^CNT_W-1 and clear on flush[i] or reset.
  - flush and hit on the same channel in the same cycle: the counter clears.
- Not defined: counters are not built; hit_cnt is tied to 0. The port list is unchanged.

## Test plan
- Single channel: ch0 sends 1,0,1,1,0 back-to-back → hit with pat=0, ch=0 the cycle after bit 3; hit with pat=1, ch=0 the cycle after bit 5; hit_cnt[ch0]=2 (macro on).
- Context isolation: ch0 sends 1,0, then releases. ch1 sends 1,1. ch0 then sends 1 → ch1 gives no hit; ch0 hits with pat=0 (101) after its third bit.
- Burst fairness, BURST=4, ch0 and ch1 always valid → in_ready pattern: ch0 ×4, one idle cycle, ch1 ×4, one idle cycle, repeating. A lone requester keeps its grant indefinitely.
- Flush: ch2 sends 1,1, then flush[2] with the next bit 0 → no hit; ctx reset. Following bits 1,0,1 → one 101 hit.
- Saturation, CNT_W=2 → 5 hits on ch3 leave hit_cnt[ch3]=3. Macro off → hit_cnt stays 0.
- Reset mid-grant with a pending hit → next cycle in_ready=0, hit=0, busy=0, all counters 0. A subsequent 1,0,1 detects normally.

Source files
------------

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one overlapping "101"/"110" Mealy detector across N_CH serial channels.
// Per-channel saturating hit counters are built only when SEQ_DET_HIT_CNT_EN is defined.
module seq_det_sched #(
  parameter int N_CH  = 4,
  parameter int BURST = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH-1:0]         in_bit,
  output logic [N_CH-1:0]         in_ready,
  input  logic [N_CH-1:0]         flush,
  output logic                    hit,
  output logic [$clog2(N_CH)-1:0] hit_ch,
  output logic                    hit_pat,
  output logic                    busy,
  output logic [N_CH*CNT_W-1:0]   hit_cnt
);
  localparam int CH_W = $clog2(N_CH);
  localparam int BC_W = $clog2(BURST + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;
  typedef enum logic [1:0] {CTX_A = 2'b00, CTX_B = 2'b01, CTX_C = 2'b10, CTX_D = 2'b11} ctx_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] gnt_q, gnt_d, rr_q, rr_d, hit_ch_q, hit_ch_d;
  logic [BC_W-1:0] burst_q, burst_d;
  logic [N_CH-1:0] in_ready_q, in_ready_d;
  logic            busy_q, busy_d, hit_q, hit_d, hit_pat_q, hit_pat_d;
  ctx_t            ctx_q [N_CH];
  ctx_t            ctx_d [N_CH];
  logic            pick_vld;
  logic [CH_W-1:0] pick_ch, scan_idx;
  logic            xfer, xfer_bit, others;
  ctx_t            cur_ctx;

  function automatic ctx_t ctx_next(input ctx_t c, input logic b);
    case (c)
      CTX_A:   return b ? CTX_B : CTX_A;
      CTX_B:   return b ? CTX_C : CTX_D;
      CTX_C:   return b ? CTX_C : CTX_D;
      default: return b ? CTX_B : CTX_A;
    endcase
  endfunction

  assign xfer     = (state_q == S_GRANT) && in_valid[gnt_q];
  assign xfer_bit = in_bit[gnt_q];
  assign cur_ctx  = ctx_q[gnt_q];
  assign others   = |(in_valid & ~(N_CH'(1) << gnt_q));

  // First valid channel at or after rr_ptr, scanning cyclically.
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      scan_idx = CH_W'((32'(rr_q) + k) % 32'(N_CH));
      if (!pick_vld && in_valid[scan_idx]) begin
        pick_vld = 1'b1;
        pick_ch  = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_GRANT;
          gnt_d   = pick_ch;
          burst_d = '0;
        end
      end
      default: begin
        if (!xfer || (burst_q == BC_W'(BURST - 1) && others)) begin
          state_d = S_IDLE;
          rr_d    = (gnt_q == CH_W'(N_CH - 1)) ? '0 : gnt_q + CH_W'(1);
        end else if (burst_q == BC_W'(BURST - 1)) begin
          burst_d = '0;
        end else begin
          burst_d = burst_q + BC_W'(1);
        end
      end
    endcase
    in_ready_d = (state_d == S_GRANT) ? (N_CH'(1) << gnt_d) : '0;
    busy_d     = (state_d == S_GRANT);
  end

  // A flush on the transferring channel swallows the bit's detection.
  always_comb begin
    hit_d     = 1'b0;
    hit_ch_d  = hit_ch_q;
    hit_pat_d = hit_pat_q;
    if (xfer && !flush[gnt_q] &&
        ((cur_ctx == CTX_C && !xfer_bit) || (cur_ctx == CTX_D && xfer_bit))) begin
      hit_d     = 1'b1;
      hit_ch_d  = gnt_q;
      hit_pat_d = (cur_ctx == CTX_C);
    end
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      ctx_d[ch] = ctx_q[ch];
      if (flush[ch])
        ctx_d[ch] = CTX_A;
      else if (xfer && gnt_q == CH_W'(ch))
        ctx_d[ch] = ctx_next(ctx_q[ch], xfer_bit);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      rr_q       <= '0;
      burst_q    <= '0;
      in_ready_q <= '0;
      busy_q     <= 1'b0;
      hit_q      <= 1'b0;
      hit_ch_q   <= '0;
      hit_pat_q  <= 1'b0;
      for (int unsigned ch = 0; ch < N_CH; ch++) ctx_q[ch] <= CTX_A;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      burst_q    <= burst_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      hit_q      <= hit_d;
      hit_ch_q   <= hit_ch_d;
      hit_pat_q  <= hit_pat_d;
      for (int unsigned ch = 0; ch < N_CH; ch++) ctx_q[ch] <= ctx_d[ch];
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign hit      = hit_q;
  assign hit_ch   = hit_ch_q;
  assign hit_pat  = hit_pat_q;

`ifdef SEQ_DET_HIT_CNT_EN
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  always_comb begin
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (flush[ch])
        cnt_d[ch] = '0;
      else if (hit_d && hit_ch_d == CH_W'(ch) && cnt_q[ch] != '1)
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned ch = 0; ch < N_CH; ch++) cnt_q[ch] <= '0;
    end else begin
      for (int unsigned ch = 0; ch < N_CH; ch++) cnt_q[ch] <= cnt_d[ch];
    end
  end

  always_comb begin
    hit_cnt = '0;
    for (int unsigned ch = 0; ch < N_CH; ch++) hit_cnt[ch*CNT_W +: CNT_W] = cnt_q[ch];
  end
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Self-checking bench for seq_det_sched: directed scenarios plus randomized traffic against a
// bit-history reference model. Counter expectations follow SEQ_DET_HIT_CNT_EN.
module tb_seq_det_sched;
  localparam int NCH  = 4;
  localparam int BRST = 4;
  localparam int CW   = 2;
  localparam int CMAX = 3;
`ifdef SEQ_DET_HIT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   in_valid = '0;
  logic [3:0]   in_bit = '0;
  logic [3:0]   flush = '0;
  logic [3:0]   in_ready;
  logic         hit;
  logic [1:0]   hit_ch;
  logic         hit_pat;
  logic         busy;
  logic [7:0]   hit_cnt;

  int total = 0;
  int bad = 0;

  seq_det_sched #(.N_CH(NCH), .BURST(BRST), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .flush(flush), .hit(hit), .hit_ch(hit_ch),
    .hit_pat(hit_pat), .busy(busy), .hit_cnt(hit_cnt)
  );

  always #5 clock = ~clock;

  // Reference model: owner (-1 = idle), per-channel bit history since last flush, hit counters.
  int         m_own, m_rr, m_bcnt, m_ch;
  int         m_len [4];
  logic [2:0] m_hist [4];
  logic       m_hit, m_pat;
  int         m_cnt [4];

  function automatic logic [3:0] m_ready();
    return (m_own >= 0) ? 4'(1 << m_own) : 4'b0000;
  endfunction

  function automatic logic [7:0] m_cnt_vec();
    logic [7:0] v;
    for (int i = 0; i < 4; i++) v[i*2 +: 2] = 2'(m_cnt[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_own = -1; m_rr = 0; m_bcnt = 0; m_hit = 0; m_ch = 0; m_pat = 0;
    for (int i = 0; i < 4; i++) begin m_len[i] = 0; m_hist[i] = 0; m_cnt[i] = 0; end
  endtask

  task automatic model_step(input logic [3:0] v, input logic [3:0] b, input logic [3:0] f);
    bit nh; int nch; bit npat;
    nh = 0; nch = 0; npat = 0;
    for (int i = 0; i < 4; i++) if (f[i]) begin m_len[i] = 0; m_hist[i] = 0; end
    if (m_own >= 0 && v[m_own] && !f[m_own]) begin
      m_hist[m_own] = {m_hist[m_own][1:0], b[m_own]};
      m_len[m_own]++;
      if (m_len[m_own] >= 3 && (m_hist[m_own] == 3'b101 || m_hist[m_own] == 3'b110)) begin
        nh = 1; nch = m_own; npat = (m_hist[m_own] == 3'b110);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (f[i]) m_cnt[i] = 0;
      else if (CNT_EN && nh && nch == i && m_cnt[i] < CMAX) m_cnt[i]++;
    end
    if (m_own < 0) begin
      for (int k = 0; k < 4; k++)
        if (m_own < 0 && v[(m_rr + k) % 4]) begin m_own = (m_rr + k) % 4; m_bcnt = 0; end
    end else if (!v[m_own]) begin
      m_rr = (m_own + 1) % 4; m_own = -1;
    end else begin
      m_bcnt++;
      if (m_bcnt == BRST) begin
        if ((v & ~(4'b0001 << m_own)) != 4'b0000) begin m_rr = (m_own + 1) % 4; m_own = -1; end
        else m_bcnt = 0;
      end
    end
    m_hit = nh;
    if (nh) begin m_ch = nch; m_pat = npat; end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] b, input logic [3:0] f);
    in_valid = v; in_bit = b; flush = f;
    model_step(v, b, f);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = '0; in_bit = '0; flush = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // Sends n bits (sq MSB-first) on channel ch; fidx marks the bit carrying a flush.
  task automatic run_seq(input int ch, input logic [15:0] sq, input int n, input int fidx,
                         output int h101, output int h110, output int mism, output bit tout);
    int idx; int cyc; bit xf; logic [15:0] s;
    s = sq; idx = 0; cyc = 0; h101 = 0; h110 = 0; mism = 0;
    while (idx < n && cyc < 60) begin
      xf = (m_own == ch);
      drive(4'(1 << ch), 4'(s[n-1-idx]) << ch, (xf && idx == fidx) ? 4'(1 << ch) : 4'b0000);
      if (xf) idx++;
      cyc++;
      if (hit !== m_hit) mism++;
      else if (m_hit && (hit_ch !== 2'(m_ch) || hit_pat !== m_pat)) mism++;
      if (hit === 1'b1) begin
        if (hit_pat) h110++; else h101++;
      end
    end
    tout = (idx < n);
  endtask

  task automatic release_ch();
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0", hit); end
    total++; if (hit_ch !== 2'd0) begin bad++; $display("FAIL reset_hit_ch got=%0d exp=0", hit_ch); end
    total++; if (hit_pat !== 1'b0) begin bad++; $display("FAIL reset_hit_pat got=%b exp=0", hit_pat); end
    total++; if (hit_cnt !== 8'h00) begin bad++; $display("FAIL reset_cnt got=%h exp=00", hit_cnt); end
  endtask

  task automatic test_single();
    int a, c, mm; bit to;
    do_reset();
    run_seq(0, 16'b10110, 5, -1, a, c, mm, to);
    total++; if (to) begin bad++; $display("FAIL single_timeout got=1 exp=0"); end
    total++; if (mm != 0) begin bad++; $display("FAIL single_timing got=%0d exp=0 mismatching cycles", mm); end
    total++; if (a != 1) begin bad++; $display("FAIL single_101 got=%0d exp=1", a); end
    total++; if (c != 1) begin bad++; $display("FAIL single_110 got=%0d exp=1", c); end
    total++; if (hit_cnt[1:0] !== (CNT_EN ? 2'd2 : 2'd0)) begin
      bad++; $display("FAIL single_cnt got=%0d exp=%0d", hit_cnt[1:0], CNT_EN ? 2 : 0);
    end
    release_ch();
  endtask

  task automatic test_isolation();
    int a, c, mm; bit to;
    do_reset();
    run_seq(0, 16'b10, 2, -1, a, c, mm, to);
    release_ch();
    run_seq(1, 16'b11, 2, -1, a, c, mm, to);
    total++; if (a + c != 0 || to) begin bad++; $display("FAIL iso_ch1 got=%0d hits exp=0", a + c); end
    release_ch();
    run_seq(0, 16'b1, 1, -1, a, c, mm, to);
    total++; if (a != 1 || c != 0 || mm != 0 || to) begin
      bad++; $display("FAIL iso_ch0 got=%0d/%0d mism=%0d exp=1/0 mism=0", a, c, mm);
    end
    total++; if (hit_ch !== 2'd0) begin bad++; $display("FAIL iso_hit_ch got=%0d exp=0", hit_ch); end
    release_ch();
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(4'b0011, 4'($urandom), 4'b0000);
      case (i % 10)
        0, 1, 2, 3: exp = 4'b0001;
        5, 6, 7, 8: exp = 4'b0010;
        default:    exp = 4'b0000;
      endcase
      total++; if (in_ready !== exp) begin bad++; $display("FAIL fair_ready[%0d] got=%b exp=%b", i, in_ready, exp); end
    end
    for (int i = 0; i < 3; i++) drive(4'b0100, 4'($urandom), 4'b0000);
    for (int i = 0; i < 10; i++) begin
      drive(4'b0100, 4'($urandom), 4'b0000);
      total++; if (in_ready !== 4'b0100 || busy !== 1'b1) begin
        bad++; $display("FAIL lone_grant[%0d] got=%b/%b exp=0100/1", i, in_ready, busy);
      end
    end
  endtask

  task automatic test_flush();
    int a, c, mm; bit to;
    do_reset();
    run_seq(2, 16'b110101, 6, 2, a, c, mm, to);
    total++; if (c != 0 || to) begin bad++; $display("FAIL flush_110 got=%0d exp=0", c); end
    total++; if (a != 1 || mm != 0) begin bad++; $display("FAIL flush_101 got=%0d mism=%0d exp=1 mism=0", a, mm); end
    total++; if (hit_cnt[5:4] !== (CNT_EN ? 2'd1 : 2'd0)) begin
      bad++; $display("FAIL flush_cnt got=%0d exp=%0d", hit_cnt[5:4], CNT_EN ? 1 : 0);
    end
    release_ch();
  endtask

  task automatic test_saturation();
    int a, c, mm; bit to;
    do_reset();
    run_seq(3, 16'b10101010101, 11, -1, a, c, mm, to);
    total++; if (a != 5 || mm != 0 || to) begin bad++; $display("FAIL sat_hits got=%0d mism=%0d exp=5", a, mm); end
    total++; if (hit_cnt !== (CNT_EN ? 8'hC0 : 8'h00)) begin
      bad++; $display("FAIL sat_cnt got=%h exp=%h", hit_cnt, CNT_EN ? 8'hC0 : 8'h00);
    end
    drive(4'b0000, 4'b0000, 4'b1000);
    total++; if (hit_cnt !== 8'h00) begin bad++; $display("FAIL sat_flush_cnt got=%h exp=00", hit_cnt); end
  endtask

  task automatic test_reset_mid();
    int a, c, mm; bit to;
    do_reset();
    run_seq(1, 16'b101, 3, -1, a, c, mm, to);
    release_ch();
    run_seq(0, 16'b10, 2, -1, a, c, mm, to);
    in_valid = 4'b0001; in_bit = 4'b0001; flush = '0; reset = 1'b1;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    total++; if (in_ready !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_grant got=%b/%b exp=0000/0", in_ready, busy);
    end
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL rstmid_hit got=%b exp=0", hit); end
    total++; if (hit_cnt !== 8'h00) begin bad++; $display("FAIL rstmid_cnt got=%h exp=00", hit_cnt); end
    reset = 1'b0;
    run_seq(0, 16'b101, 3, -1, a, c, mm, to);
    total++; if (a != 1 || c != 0 || mm != 0 || to) begin
      bad++; $display("FAIL rstmid_after got=%0d/%0d mism=%0d exp=1/0", a, c, mm);
    end
    release_ch();
  endtask

  task automatic test_random();
    logic [3:0] v, b, f;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v = 4'($urandom) | 4'($urandom);
      b = 4'($urandom);
      f = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
      drive(v, b, f);
      total++; if (in_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, in_ready, m_ready()); end
      total++; if (busy !== (m_own >= 0)) begin bad++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", i, busy, m_own >= 0); end
      total++; if (hit !== m_hit) begin bad++; $display("FAIL rnd_hit[%0d] got=%b exp=%b", i, hit, m_hit); end
      if (m_hit) begin
        total++; if (hit_ch !== 2'(m_ch) || hit_pat !== m_pat) begin
          bad++; $display("FAIL rnd_hitinfo[%0d] got=%0d/%b exp=%0d/%b", i, hit_ch, hit_pat, m_ch, m_pat);
        end
      end
      total++; if (hit_cnt !== m_cnt_vec()) begin bad++; $display("FAIL rnd_cnt[%0d] got=%h exp=%h", i, hit_cnt, m_cnt_vec()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_isolation();
    test_fairness();
    test_flush();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
